// File: rtl/fft_frame_serializer.sv
// Captures 16-bin parallel FFT frames into a 2-deep ping-pong buffer and replays
// them one bin per beat on a valid/ready stream; frames arriving when full are dropped.
module fft_frame_serializer #(
    parameter int NBINS = 16,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fft_valid,
    input  logic [DW-1:0] fft_d0,
    input  logic [DW-1:0] fft_d1,
    input  logic [DW-1:0] fft_d2,
    input  logic [DW-1:0] fft_d3,
    input  logic [DW-1:0] fft_d4,
    input  logic [DW-1:0] fft_d5,
    input  logic [DW-1:0] fft_d6,
    input  logic [DW-1:0] fft_d7,
    input  logic [DW-1:0] fft_d8,
    input  logic [DW-1:0] fft_d9,
    input  logic [DW-1:0] fft_d10,
    input  logic [DW-1:0] fft_d11,
    input  logic [DW-1:0] fft_d12,
    input  logic [DW-1:0] fft_d13,
    input  logic [DW-1:0] fft_d14,
    input  logic [DW-1:0] fft_d15,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_bin,
    output logic          out_last,
    input  logic          ovf_clr,
    output logic          overflow,
    output logic [1:0]    frames_pending
);

    logic [DW-1:0] fft_bins [NBINS];
    logic [DW-1:0] frame_mem [2][NBINS];

    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic [1:0] count_q, count_d;
    logic [3:0] bin_idx_q, bin_idx_d;
    logic       overflow_q, overflow_d;

    logic valid, handshake, last_hs, space, accept, drop;

    always_comb begin
        fft_bins[0]  = fft_d0;   fft_bins[1]  = fft_d1;
        fft_bins[2]  = fft_d2;   fft_bins[3]  = fft_d3;
        fft_bins[4]  = fft_d4;   fft_bins[5]  = fft_d5;
        fft_bins[6]  = fft_d6;   fft_bins[7]  = fft_d7;
        fft_bins[8]  = fft_d8;   fft_bins[9]  = fft_d9;
        fft_bins[10] = fft_d10;  fft_bins[11] = fft_d11;
        fft_bins[12] = fft_d12;  fft_bins[13] = fft_d13;
        fft_bins[14] = fft_d14;  fft_bins[15] = fft_d15;
    end

    always_comb begin
        valid      = (count_q != 2'd0);
        handshake  = valid & out_ready;
        last_hs    = handshake & (bin_idx_q == 4'd15);
        // A full buffer still takes a frame when its oldest frame finishes this cycle.
        space      = (count_q < 2'd2) | last_hs;
        accept     = fft_valid & space;
        drop       = fft_valid & ~space;

        wr_sel_d   = wr_sel_q ^ accept;
        rd_sel_d   = rd_sel_q ^ last_hs;
        count_d    = count_q + 2'(accept) - 2'(last_hs);
        bin_idx_d  = handshake ? bin_idx_q + 4'd1 : bin_idx_q;
        overflow_d = overflow_q;
        if (drop)
            overflow_d = 1'b1;
        else if (ovf_clr)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            count_q    <= '0;
            bin_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            count_q    <= count_d;
            bin_idx_q  <= bin_idx_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned k = 0; k < NBINS; k++)
                frame_mem[wr_sel_q][k] <= fft_bins[k];
        end
    end

    always_comb begin
        out_valid      = valid;
        out_data       = valid ? frame_mem[rd_sel_q][bin_idx_q] : '0;
        out_bin        = valid ? bin_idx_q : '0;
        out_last       = valid & (bin_idx_q == 4'd15);
        overflow       = overflow_q;
        frames_pending = count_q;
    end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Randomized and directed bench for fft_frame_serializer; a queue of expected beats
// is filled by the driver and drained by a negedge monitor.
module tb_fft_frame_serializer;

    logic        clk = 1'b0;
    logic        rst, fft_valid, out_ready, ovf_clr;
    logic [31:0] tb_d [16];
    logic        out_valid, out_last, overflow;
    logic [31:0] out_data;
    logic [3:0]  out_bin;
    logic [1:0]  frames_pending;

    always #5 clk = ~clk;

    fft_frame_serializer #(.NBINS(16), .DW(32)) dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(tb_d[0]),   .fft_d1(tb_d[1]),   .fft_d2(tb_d[2]),   .fft_d3(tb_d[3]),
        .fft_d4(tb_d[4]),   .fft_d5(tb_d[5]),   .fft_d6(tb_d[6]),   .fft_d7(tb_d[7]),
        .fft_d8(tb_d[8]),   .fft_d9(tb_d[9]),   .fft_d10(tb_d[10]), .fft_d11(tb_d[11]),
        .fft_d12(tb_d[12]), .fft_d13(tb_d[13]), .fft_d14(tb_d[14]), .fft_d15(tb_d[15]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bin(out_bin), .out_last(out_last), .ovf_clr(ovf_clr),
        .overflow(overflow), .frames_pending(frames_pending)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  bin;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    bit    ovf_m;
    bit    mon_en;
    int    total, bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus, starting just after a rising edge.
    task automatic step(input bit fv, input bit rdy, input bit clr, input bit pat);
        int sz;
        int pend;
        bit acc;
        logic [15:0] kk;
        sz   = exp_q.size();
        pend = (sz + 15) / 16;
        fft_valid = fv;
        out_ready = rdy;
        ovf_clr   = clr;
        if (fv) begin
            for (int k = 0; k < 16; k++) begin
                kk = 16'(k);
                tb_d[k] = pat ? {kk, ~kk} : $urandom;
            end
        end
        // Full queue only admits a frame if the head frame's final beat leaves now.
        acc = fv && (pend < 2 || (pend == 2 && rdy && sz == 17));
        @(posedge clk);
        #1;
        if (acc)
            for (int k = 0; k < 16; k++)
                exp_q.push_back('{data: tb_d[k], bin: 4'(k), last: (k == 15)});
        if (fv && !acc)
            ovf_m = 1'b1;
        else if (clr)
            ovf_m = 1'b0;
        fft_valid = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        beat_t e;
        bit    ev;
        if (mon_en && rst) begin
            ev = (exp_q.size() != 0);
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("frames_pending", 32'(frames_pending), 32'((exp_q.size() + 15) / 16));
            chk("overflow", 32'(overflow), 32'(ovf_m));
            if (out_valid && ev) begin
                e = exp_q[0];
                chk("out_data", out_data, e.data);
                chk("out_bin", 32'(out_bin), 32'(e.bin));
                chk("out_last", 32'(out_last), 32'(e.last));
                if (out_ready)
                    void'(exp_q.pop_front());
            end else if (!out_valid) begin
                chk("idle_data", out_data, 32'd0);
                chk("idle_bin_last", 32'({out_bin, out_last}), 32'd0);
            end
        end
    end

    initial begin
        total = 0; bad = 0; ovf_m = 1'b0; mon_en = 1'b0;
        rst = 1'b0; fft_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        for (int k = 0; k < 16; k++) tb_d[k] = '0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_bin_last", 32'({out_bin, out_last}), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_pending", 32'(frames_pending), 32'd0);
        #20 rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // single frame, always ready
        step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (18) step(1'b0, 1'b1, 1'b0, 1'b0);

        // backpressure 1,0,0,1,...
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++)
            step(1'b0, (i % 3 == 0), 1'b0, 1'b0);
        chk("bp_remaining", 32'(exp_q.size()), 32'd0);

        // overflow: A, B kept, C dropped
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // ovf_clr alone, then clear racing a drop
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // capture coinciding with last beat of a full buffer
        repeat (15) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // random traffic
        repeat (800)
            step(($urandom % 4 == 0), ($urandom % 3 != 0), ($urandom % 16 == 0), 1'b0);
        drain();

        // reset during bin 7
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_bin_last", 32'({out_bin, out_last}), 32'd0);
        chk("mid_rst_pending", 32'(frames_pending), 32'd0);
        exp_q.delete();
        ovf_m = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        step(1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
